// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared types and constants for the two-host register-bank arbiter.
//   - ADDR_W_DEF / DATA_W_DEF : default bank address / data widths
//   - op_e                    : bank operation granted to a host
//   - state_e                 : arbiter FSM states
//   - STAT_*                  : bit positions inside the 3-bit host status word
// -----------------------------------------------------------------------------
package reg_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam int STAT_W        = 3;
  localparam int STAT_OVERRUN  = 2;
  localparam int STAT_WR_PEND  = 1;
  localparam int STAT_RD_STALE = 0;

endpackage

// File: rtl/reg_arb_host_slot.sv
// -----------------------------------------------------------------------------
// reg_arb_host_slot
// Per-host front end of the register-bank arbiter. Captures the host's write
// strobe, keeps a one-entry pending write, tracks the address of the last
// completed read and holds the prefetched read data for the host.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   addr_i          : host address (also the write address on a strobe)
//   wdata_i         : host write data
//   we_i            : host write strobe, one-cycle pulse
//   wr_done_i       : this slot's pending write is being performed this cycle
//   rd_done_i       : this slot's read is being performed this cycle
//   inval_all_i     : some write (either host) is being performed this cycle
//   rd_addr_i       : address of the read being performed
//   rd_data_i       : bank data for that read
//   req_o           : slot wants a bank access
//   op_o            : operation wanted (writes before reads)
//   wr_addr_o/wr_data_o : pending write address / data
//   rdata_o         : prefetched read data
//   status_o        : {overrun, wr_pending, rd_stale}
// -----------------------------------------------------------------------------
module reg_arb_host_slot
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic              wr_done_i,
  input  logic              rd_done_i,
  input  logic              inval_all_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  output logic              req_o,
  output op_e               op_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [STAT_W-1:0] status_o
);

  logic              wr_pend_q,      wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q,      wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,      wr_data_d;
  logic              overrun_q,      overrun_d;
  logic              invalid_q,      invalid_d;
  logic [ADDR_W-1:0] last_rd_addr_q, last_rd_addr_d;
  logic [DATA_W-1:0] rdata_q,        rdata_d;
  logic              rd_stale;

  assign rd_stale = invalid_q | (addr_i != last_rd_addr_q);

  always_comb begin
    wr_pend_d      = wr_pend_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    overrun_d      = overrun_q;
    invalid_d      = invalid_q;
    last_rd_addr_d = last_rd_addr_q;
    rdata_d        = rdata_q;

    if (wr_done_i) begin
      wr_pend_d = 1'b0;
    end

    // The single write buffer frees up in the cycle its write is performed,
    // so a strobe landing on that cycle is accepted rather than dropped.
    if (we_i) begin
      if (!wr_pend_q || wr_done_i) begin
        wr_pend_d = 1'b1;
        wr_addr_d = addr_i;
        wr_data_d = wdata_i;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // Any write may alias this host's address, so every write forces a refresh.
    if (inval_all_i) begin
      invalid_d = 1'b1;
    end

    // The data is taken even if the host has already moved on; the address
    // compare keeps rd_stale high so another read follows.
    if (rd_done_i) begin
      rdata_d        = rd_data_i;
      last_rd_addr_d = rd_addr_i;
      invalid_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend_q      <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      overrun_q      <= 1'b0;
      invalid_q      <= 1'b1;
      last_rd_addr_q <= '0;
      rdata_q        <= '0;
    end else begin
      wr_pend_q      <= wr_pend_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      overrun_q      <= overrun_d;
      invalid_q      <= invalid_d;
      last_rd_addr_q <= last_rd_addr_d;
      rdata_q        <= rdata_d;
    end
  end

  assign req_o     = wr_pend_q | rd_stale;
  assign op_o      = wr_pend_q ? OP_WRITE : OP_READ;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rdata_o   = rdata_q;

  // invalid is held set during reset so the host refreshes straight after
  // release; the stale flag is masked so status reads all-zero while in reset.
  always_comb begin
    status_o                = '0;
    status_o[STAT_OVERRUN]  = overrun_q;
    status_o[STAT_WR_PEND]  = wr_pend_q;
    status_o[STAT_RD_STALE] = rd_stale & rst_n;
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// reg_access_arbiter
// Shares one single-port register bank between host 0 (SPI) and host 1 (I2C).
// Each host presents addr/wdata/we and sees a continuously valid rdata that is
// kept coherent with its current address and with every completed write.
// Bank accesses are serialised with round-robin arbitration, one access per
// two cycles (ARB cycle, then ACCESS cycle).
//
// Ports
//   clk, rst_n                        : clock, asynchronous active-low reset
//   hN_addr, hN_wdata, hN_we          : host N application bus inputs
//   hN_rdata                          : host N prefetched read data
//   hN_status                         : host N {overrun, wr_pending, rd_stale}
//   mem_en, mem_we, mem_addr, mem_wdata : registered bank controls
//   mem_rdata                         : bank read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] h0_addr,
  input  logic [DATA_W-1:0] h0_wdata,
  input  logic              h0_we,
  output logic [DATA_W-1:0] h0_rdata,
  output logic [STAT_W-1:0] h0_status,
  input  logic [ADDR_W-1:0] h1_addr,
  input  logic [DATA_W-1:0] h1_wdata,
  input  logic              h1_we,
  output logic [DATA_W-1:0] h1_rdata,
  output logic [STAT_W-1:0] h1_status,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              req0, req1;
  op_e               op0, op1;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1;
  logic [DATA_W-1:0] wr_data0, wr_data1;

  state_e            state_q,     state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q,     grant_d;
  op_e               op_q,        op_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              grant_sel;
  op_e               sel_op;
  logic              in_access;
  logic              wr_done0, wr_done1, rd_done0, rd_done1, inval_all;

  // Completion strobes decoded from the access currently on the bank.
  assign in_access = (state_q == ST_ACCESS);
  assign inval_all = in_access & (op_q == OP_WRITE);
  assign wr_done0  = inval_all & ~grant_q;
  assign wr_done1  = inval_all &  grant_q;
  assign rd_done0  = in_access & (op_q == OP_READ) & ~grant_q;
  assign rd_done1  = in_access & (op_q == OP_READ) &  grant_q;

  reg_arb_host_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (h0_addr),
    .wdata_i     (h0_wdata),
    .we_i        (h0_we),
    .wr_done_i   (wr_done0),
    .rd_done_i   (rd_done0),
    .inval_all_i (inval_all),
    .rd_addr_i   (mem_addr_q),
    .rd_data_i   (mem_rdata),
    .req_o       (req0),
    .op_o        (op0),
    .wr_addr_o   (wr_addr0),
    .wr_data_o   (wr_data0),
    .rdata_o     (h0_rdata),
    .status_o    (h0_status)
  );

  reg_arb_host_slot #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_slot1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_i      (h1_addr),
    .wdata_i     (h1_wdata),
    .we_i        (h1_we),
    .wr_done_i   (wr_done1),
    .rd_done_i   (rd_done1),
    .inval_all_i (inval_all),
    .rd_addr_i   (mem_addr_q),
    .rd_data_i   (mem_rdata),
    .req_o       (req1),
    .op_o        (op1),
    .wr_addr_o   (wr_addr1),
    .wr_data_o   (wr_data1),
    .rdata_o     (h1_rdata),
    .status_o    (h1_status)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_d         = op_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    // On a conflict the host that did not win last time goes first.
    grant_sel = (req0 && req1) ? ~last_grant_q : req1;
    sel_op    = grant_sel ? op1 : op0;

    case (state_q)
      ST_ARB: begin
        if (req0 || req1) begin
          state_d     = ST_ACCESS;
          grant_d     = grant_sel;
          op_d        = sel_op;
          mem_en_d    = 1'b1;
          mem_we_d    = (sel_op == OP_WRITE);
          if (sel_op == OP_WRITE) begin
            mem_addr_d = grant_sel ? wr_addr1 : wr_addr0;
          end else begin
            mem_addr_d = grant_sel ? h1_addr : h0_addr;
          end
          mem_wdata_d = grant_sel ? wr_data1 : wr_data0;
        end
      end
      ST_ACCESS: begin
        last_grant_d = grant_q;
        state_d      = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // last_grant resets to host 1 so host 0 wins the first conflict.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      op_q         <= OP_READ;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_q         <= op_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_access_arbiter
// Directed and random stimulus for reg_access_arbiter. A transaction-level
// reference model (per-host pending write, last read address, prefetched data,
// plus one in-flight bank access) is stepped once per clock and compared with
// every DUT output after each edge.
// -----------------------------------------------------------------------------
module tb_reg_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a  [2];
  logic [7:0] wd [2];
  logic       we [2];

  logic [7:0] h0_addr, h1_addr, h0_wdata, h1_wdata;
  logic       h0_we, h1_we;
  logic [7:0] h0_rdata, h1_rdata;
  logic [2:0] h0_status, h1_status;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem [256];

  assign h0_addr   = a[0];
  assign h1_addr   = a[1];
  assign h0_wdata  = wd[0];
  assign h1_wdata  = wd[1];
  assign h0_we     = we[0];
  assign h1_we     = we[1];
  assign mem_rdata = mem[mem_addr];

  always #5 clk = ~clk;

  reg_access_arbiter #(
    .ADDR_W (8),
    .DATA_W (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .h0_addr   (h0_addr),
    .h0_wdata  (h0_wdata),
    .h0_we     (h0_we),
    .h0_rdata  (h0_rdata),
    .h0_status (h0_status),
    .h1_addr   (h1_addr),
    .h1_wdata  (h1_wdata),
    .h1_we     (h1_we),
    .h1_rdata  (h1_rdata),
    .h1_status (h1_status),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pend;
    logic [7:0] pa;
    logic [7:0] pd;
    logic       ovr;
    logic       inval;
    logic [7:0] lra;
    logic [7:0] rd;
  } hst_t;

  hst_t       m [2];
  logic [7:0] ref_bank [256];
  bit         acc_v, acc_w;
  int         acc_h, lastg;
  logic [7:0] acc_a, acc_d;
  logic       m_en, m_we;
  logic [7:0] m_addr, m_wd;

  int total = 0;
  int bad   = 0;
  int wr_seen = 0;
  logic [15:0] wlog [$];

  function automatic bit stale(input int h);
    return m[h].inval || (a[h] != m[h].lra);
  endfunction

  function automatic logic [2:0] exp_status(input int h);
    if (!rst_n) return 3'b000;
    return {m[h].ovr, m[h].pend, stale(h)};
  endfunction

  function automatic bit busy();
    return acc_v || m[0].pend || stale(0) || m[1].pend || stale(1);
  endfunction

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m[h] = '{pend: 1'b0, pa: 8'h00, pd: 8'h00, ovr: 1'b0, inval: 1'b1,
               lra: 8'h00, rd: 8'h00};
    end
    acc_v  = 0;
    acc_w  = 0;
    acc_h  = 0;
    lastg  = 1;
    m_en   = 1'b0;
    m_we   = 1'b0;
    m_addr = 8'h00;
    m_wd   = 8'h00;
  endtask

  // One clock edge of the reference: finish the in-flight access or pick the
  // next one, then apply this cycle's write strobes.
  task automatic model_step();
    hst_t nm [2];
    bit   wdone [2];
    bit   r0, r1;
    int   g;
    nm    = m;
    wdone = '{0, 0};
    if (acc_v) begin
      if (acc_w) begin
        ref_bank[acc_a] = acc_d;
        nm[acc_h].pend  = 1'b0;
        nm[0].inval     = 1'b1;
        nm[1].inval     = 1'b1;
        wdone[acc_h]    = 1;
      end else begin
        nm[acc_h].rd    = ref_bank[acc_a];
        nm[acc_h].lra   = acc_a;
        nm[acc_h].inval = 1'b0;
      end
      lastg = acc_h;
      acc_v = 0;
      m_en  = 1'b0;
    end else begin
      r0 = m[0].pend || stale(0);
      r1 = m[1].pend || stale(1);
      if (r0 || r1) begin
        g      = (r0 && r1) ? 1 - lastg : (r0 ? 0 : 1);
        acc_v  = 1;
        acc_h  = g;
        acc_w  = m[g].pend;
        acc_a  = acc_w ? m[g].pa : a[g];
        acc_d  = m[g].pd;
        m_en   = 1'b1;
        m_we   = acc_w;
        m_addr = acc_a;
        m_wd   = acc_d;
      end
    end
    for (int h = 0; h < 2; h++) begin
      if (we[h]) begin
        if (!m[h].pend || wdone[h]) begin
          nm[h].pend = 1'b1;
          nm[h].pa   = a[h];
          nm[h].pd   = wd[h];
        end else begin
          nm[h].ovr = 1'b1;
        end
      end
    end
    m = nm;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rdata0",  32'(h0_rdata),  32'(m[0].rd));
    chk("rdata1",  32'(h1_rdata),  32'(m[1].rd));
    chk("status0", 32'(h0_status), 32'(exp_status(0)));
    chk("status1", 32'(h1_status), 32'(exp_status(1)));
    chk("membus",  32'({mem_en, mem_we, mem_addr, mem_wdata}),
                   32'({m_en, m_we, m_addr, m_wd}));
  endtask

  // Bank write is applied just after the edge; no read completes on an edge
  // that also completes a write, so the ordering is harmless.
  task automatic tick();
    logic       do_wr;
    logic [7:0] wa, wdv;
    do_wr = mem_en && mem_we;
    wa    = mem_addr;
    wdv   = mem_wdata;
    if (rst_n) model_step();
    @(posedge clk);
    if (do_wr) begin
      mem[wa] = wdv;
      wr_seen++;
      wlog.push_back({wa, wdv});
    end
    #1;
    check_all();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy() && n < 40) begin
      tick();
      n++;
    end
    total++;
    assert (n < 40)
    else begin
      bad++;
      $error("FAIL %s observed=busy expected=idle", tag);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pre41, pre_w, w_addr;
    int         n, wrs;

    rst_n = 1'b0;
    for (int h = 0; h < 2; h++) begin
      a[h]  = 8'h00;
      wd[h] = 8'h00;
      we[h] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h00] = 8'h5A;
    mem[8'h30] = 8'hC3;
    mem[8'h31] = 8'h3C;
    mem[8'h41] = 8'h5B;
    for (int i = 0; i < 256; i++) ref_bank[i] = mem[i];
    pre41 = mem[8'h41];
    model_reset();

    // Reset values
    #12;
    check_all();
    tick();
    rst_n = 1'b1;

    // Post-reset refresh: host 0 first, then host 1
    tick();
    tick();
    chk("refresh_h0_first", 32'(h0_rdata), 32'h5A);
    chk("refresh_h1_later", 32'(h1_rdata), 32'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("refresh_h0", 32'(h0_rdata), 32'h5A);
    chk("refresh_h1", 32'(h1_rdata), 32'h5A);
    chk("refresh_st0", 32'(h0_status), 32'h0);
    chk("refresh_st1", 32'(h1_status), 32'h0);

    // Host 1 writes 0xA5 to 0x10 and moves there
    a[1] = 8'h10; wd[1] = 8'hA5; we[1] = 1'b1;
    tick();
    we[1] = 1'b0;
    n = 0;
    while (h1_rdata !== 8'hA5 && n < 12) begin
      tick();
      n++;
    end
    chk("h1_sees_A5", 32'(h1_rdata), 32'hA5);
    wait_idle("idle_after_h1_wr");
    chk("h0_reread", 32'(h0_rdata), 32'h5A);

    // Uncontended write to the host's current address: bank write two cycles on
    a[0] = 8'h00; wd[0] = 8'h3C; we[0] = 1'b1;
    tick();
    we[0] = 1'b0;
    tick();
    chk("wr_latency_bus", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 8'h00, 8'h3C}));
    wait_idle("idle_after_lat");
    chk("h0_sees_3C", 32'(h0_rdata), 32'h3C);

    // Same-address writes from both hosts, host 0 holding priority
    a[0] = 8'h20;
    wait_idle("idle_h0_move");
    a[1] = 8'h20;
    wait_idle("idle_h1_move");
    wlog.delete();
    wd[0] = 8'h11; wd[1] = 8'h22; we[0] = 1'b1; we[1] = 1'b1;
    tick();
    we[0] = 1'b0; we[1] = 1'b0;
    wait_idle("idle_after_both");
    chk("both_wr_count", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("both_wr_first",  32'(wlog[0]), 32'h2011);
      chk("both_wr_second", 32'(wlog[1]), 32'h2022);
    end
    chk("bank20",      32'(mem[8'h20]), 32'h22);
    chk("both_rd_h0",  32'(h0_rdata),   32'h22);
    chk("both_rd_h1",  32'(h1_rdata),   32'h22);

    // Host 0 double strobe while host 1 keeps the bank busy
    a[0] = 8'h40; wd[0] = 8'h77; we[0] = 1'b1;
    a[1] = 8'h60;
    tick();
    a[0] = 8'h41; wd[0] = 8'h88; we[0] = 1'b1;
    a[1] = 8'h61;
    tick();
    we[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a[1] = (i % 2 == 0) ? 8'h60 : 8'h61;
      tick();
    end
    wait_idle("idle_after_ovr");
    chk("overrun_set", 32'(h0_status[2]), 32'd1);
    chk("first_wr_ok", 32'(mem[8'h40]),   32'h77);
    chk("second_drop", 32'(mem[8'h41]),   32'(pre41));

    // Host 0 address moves during its own read access
    a[0] = 8'h30;
    tick();
    a[0] = 8'h31;
    tick();
    chk("step_old_data", 32'(h0_rdata),     32'hC3);
    chk("step_stale_1",  32'(h0_status[0]), 32'd1);
    tick();
    tick();
    chk("step_new_data", 32'(h0_rdata),     32'h3C);
    chk("step_stale_0",  32'(h0_status[0]), 32'd0);
    chk("ovr_sticky",    32'(h0_status[2]), 32'd1);

    // Reset in the middle of a write access
    wait_idle("idle_before_rst");
    w_addr = a[1];
    pre_w  = mem[w_addr];
    wd[1]  = 8'h99; we[1] = 1'b1;
    tick();
    we[1] = 1'b0;
    tick();
    chk("rst_wr_in_access", 32'({mem_en, mem_we, mem_addr}), 32'({2'b11, w_addr}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_en", 32'(mem_en),    32'd0);
    chk("rst_st0",      32'(h0_status), 32'd0);
    chk("rst_st1",      32'(h1_status), 32'd0);
    model_reset();
    wrs = wr_seen;
    tick();
    tick();
    rst_n = 1'b1;
    wait_idle("idle_after_rst");
    chk("rst_no_write",  32'(wr_seen),     32'(wrs));
    chk("rst_bank_kept", 32'(mem[w_addr]), 32'(pre_w));
    chk("rst_reread0",   32'(h0_rdata),    32'(mem[a[0]]));
    chk("rst_reread1",   32'(h1_rdata),    32'(mem[a[1]]));
    chk("rst_st0_clean", 32'(h0_status),   32'd0);

    // Random traffic on a small address window
    for (int i = 0; i < 400; i++) begin
      for (int h = 0; h < 2; h++) begin
        if ($urandom_range(0, 3) == 0) a[h] = 8'($urandom_range(0, 3));
        wd[h] = 8'($urandom);
        we[h] = ($urandom_range(0, 4) == 0);
      end
      tick();
    end
    we[0] = 1'b0;
    we[1] = 1'b0;
    wait_idle("idle_after_rand");
    chk("rand_final0", 32'(h0_rdata), 32'(mem[a[0]]));
    chk("rand_final1", 32'(h1_rdata), 32'(mem[a[1]]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
